// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle sequencer driving an external 16-bit
// Nand2Tetris-style ALU (control word {zx,nx,zy,ny,f,no}).
//
// One request is taken through a valid/ready handshake. The block drives the
// ALU for one or more cycles and returns a registered result through a
// second valid/ready handshake. Multiply and variable left shift reuse the
// ALU adder, so no second adder is needed.
//
// Operations (req_op):
//   00 SINGLE : one ALU cycle with the caller's control word
//   01 MUL    : shift-and-add, one ALU cycle per multiplier bit
//   10 SHL    : A << req_b[3:0], by repeated doubling (acc + acc)
//   11 ZERO   : one ALU cycle with the ZERO control word
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready high only in IDLE)
//   req_op/c/a/b        operation, ALU control, operands
//   res_valid/ready     result handshake (valid high only in DONE)
//   res_data            result register, kept until the next result
//   busy                high while executing
//   alu_x/alu_y/alu_c   ALU operand and control drive
//   alu_out             combinational ALU output
//
// Build option:
//   ALU_SEQ_EARLY_EXIT_EN  MUL stops as soon as the remaining multiplier
//                          bits are all zero, instead of always taking
//                          16 cycles.

module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_c,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_c,
    input  logic [15:0] alu_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b01;
    localparam logic [1:0] OP_SHL    = 2'b10;
    localparam logic [1:0] OP_ZERO   = 2'b11;

    localparam logic [5:0] C_ADD   = 6'b000010;
    localparam logic [5:0] C_PASSX = 6'b001100;
    localparam logic [5:0] C_ZERO  = 6'b101010;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [5:0]  r_c;
    logic [15:0] r_acc;
    logic [15:0] r_a_sh;
    logic [15:0] r_b_sh;   // multiplier for MUL, shift count in [3:0] for SHL
    logic [3:0]  r_cnt;
    logic [15:0] r_res_data;
    logic        r_req_ready;
    logic        r_res_valid;
    logic        r_busy;

    logic        w_last;
    logic [15:0] w_alu_x;
    logic [15:0] w_alu_y;
    logic [5:0]  w_alu_c;

    // Decide whether the current EXEC cycle is the final one for the latched op
    always_comb begin
        w_last = 1'b1;
        case (r_op)
            OP_SINGLE: w_last = 1'b1;
            OP_ZERO:   w_last = 1'b1;
`ifdef ALU_SEQ_EARLY_EXIT_EN
            // Stop once the multiplier left after this shift has no set bits.
            OP_MUL:    w_last = (r_b_sh[15:1] == 15'd0);
`else
            OP_MUL:    w_last = (r_cnt == 4'd15);
`endif
            // A zero count still runs one cycle (PASSX), so it is final at once.
            OP_SHL:    w_last = (r_b_sh[3:0] == 4'd0) ||
                                (r_cnt == (r_b_sh[3:0] - 4'd1));
            default:   w_last = 1'b1;
        endcase
    end

    // ALU drive, decoded from the state registers only; parked on ZERO outside EXEC
    always_comb begin
        w_alu_x = 16'h0000;
        w_alu_y = 16'h0000;
        w_alu_c = C_ZERO;
        if (r_state == ST_EXEC) begin
            case (r_op)
                OP_SINGLE: begin
                    w_alu_x = r_a_sh;
                    w_alu_y = r_b_sh;
                    w_alu_c = r_c;
                end
                OP_MUL: begin
                    w_alu_x = r_acc;
                    w_alu_y = r_a_sh;
                    w_alu_c = r_b_sh[0] ? C_ADD : C_PASSX;
                end
                OP_SHL: begin
                    w_alu_x = r_acc;
                    w_alu_y = r_acc;
                    w_alu_c = (r_b_sh[3:0] == 4'd0) ? C_PASSX : C_ADD;
                end
                OP_ZERO: begin
                    w_alu_x = 16'h0000;
                    w_alu_y = 16'h0000;
                    w_alu_c = C_ZERO;
                end
                default: begin
                    w_alu_x = 16'h0000;
                    w_alu_y = 16'h0000;
                    w_alu_c = C_ZERO;
                end
            endcase
        end else begin
            w_alu_x = 16'h0000;
            w_alu_y = 16'h0000;
            w_alu_c = C_ZERO;
        end
    end

    // Sequencer FSM with its datapath registers and the registered handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= 2'b00;
            r_c         <= 6'b000000;
            r_acc       <= 16'h0000;
            r_a_sh      <= 16'h0000;
            r_b_sh      <= 16'h0000;
            r_cnt       <= 4'd0;
            r_res_data  <= 16'h0000;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state     <= ST_EXEC;
                        r_op        <= req_op;
                        r_c         <= req_c;
                        // MUL accumulates from zero; SHL doubles A in place.
                        r_acc       <= (req_op == OP_MUL) ? 16'h0000 : req_a;
                        r_a_sh      <= req_a;
                        r_b_sh      <= req_b;
                        r_cnt       <= 4'd0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_MUL) begin
                        r_acc  <= alu_out;
                        r_a_sh <= {r_a_sh[14:0], 1'b0};
                        r_b_sh <= {1'b0, r_b_sh[15:1]};
                        r_cnt  <= r_cnt + 4'd1;
                    end else if (r_op == OP_SHL) begin
                        r_acc  <= alu_out;
                        r_cnt  <= r_cnt + 4'd1;
                    end
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_res_data  <= alu_out;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = r_busy;
    assign alu_x     = w_alu_x;
    assign alu_y     = w_alu_y;
    assign alu_c     = w_alu_c;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq. Contains its own model of the
// Nand2Tetris ALU, feeding alu_out combinationally from the DUT's drive.

module tb_alu_seq;

    localparam logic [5:0] C_ADD   = 6'b000010;
    localparam logic [5:0] C_PASSX = 6'b001100;
    localparam logic [5:0] C_ZERO  = 6'b101010;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [5:0]  req_c;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_c;
    logic [15:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_c     (req_c),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_c     (alu_c),
        .alu_out   (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: zx, nx, zy, ny, f (add/and), no
    logic [15:0] m_x, m_y, m_o;
    always_comb begin
        m_x = alu_x;
        m_y = alu_y;
        if (alu_c[5]) m_x = 16'h0000;
        if (alu_c[4]) m_x = ~m_x;
        if (alu_c[3]) m_y = 16'h0000;
        if (alu_c[2]) m_y = ~m_y;
        m_o = alu_c[1] ? (m_x + m_y) : (m_x & m_y);
        if (alu_c[0]) m_o = ~m_o;
    end
    assign alu_out = m_o;

    // Present one request on an idle DUT for exactly the accepting edge.
    task automatic send(input logic [1:0] op, input logic [5:0] c,
                        input logic [15:0] a, input logic [15:0] b);
        req_op    = op;
        req_c     = c;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges after the accept until res_valid rises (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (!res_valid && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Take the result with a one-cycle res_ready pulse.
    task automatic take();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_flags: rdy=%b vld=%b busy=%b data=%h, want 1 0 0 0000",
                     req_ready, res_valid, busy, res_data);
        end
        n_checks++;
        if (alu_x !== 16'h0000 || alu_y !== 16'h0000 || alu_c !== C_ZERO) begin
            n_fail++;
            $display("FAIL reset_drive: x=%h y=%h c=%b, want 0000 0000 %b", alu_x, alu_y, alu_c, C_ZERO);
        end
    endtask

    task automatic test_single();
        int e;
        send(2'b00, 6'b000000, 16'h0F0F, 16'h00FF);
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || alu_x !== 16'h0F0F || alu_y !== 16'h00FF || alu_c !== 6'b000000) begin
            n_fail++;
            $display("FAIL single_exec: busy=%b rdy=%b x=%h y=%h c=%b, want 1 0 0f0f 00ff 000000",
                     busy, req_ready, alu_x, alu_y, alu_c);
        end
        wait_done(e);
        n_checks++;
        if (e !== 1 || res_data !== 16'h000F || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: edges=%0d data=%h busy=%b, want 1 000f 0", e, res_data, busy);
        end
        take();
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || alu_x !== 16'h0000 || alu_y !== 16'h0000 || alu_c !== C_ZERO) begin
            n_fail++;
            $display("FAIL single_idle: rdy=%b vld=%b x=%h y=%h c=%b", req_ready, res_valid, alu_x, alu_y, alu_c);
        end
    endtask

    task automatic test_mul();
        logic [15:0] va [3] = '{16'h0007, 16'h1234, 16'hFFFF};
        logic [15:0] vb [3] = '{16'h0006, 16'h0100, 16'hFFFF};
        logic [15:0] vr [3] = '{16'h002A, 16'h3400, 16'h0001};
`ifdef ALU_SEQ_EARLY_EXIT_EN
        int          vl [3] = '{3, 9, 16};
`else
        int          vl [3] = '{16, 16, 16};
`endif
        int e;
        for (int i = 0; i < 3; i++) begin
            send(2'b01, 6'b000000, va[i], vb[i]);
            wait_done(e);
            n_checks++;
            if (e !== vl[i] || res_data !== vr[i]) begin
                n_fail++;
                $display("FAIL mul_%0d: edges=%0d data=%h, want %0d %h", i, e, res_data, vl[i], vr[i]);
            end
            take();
            n_checks++;
            if (req_ready !== 1'b1 || alu_x !== 16'h0000 || alu_y !== 16'h0000 || alu_c !== C_ZERO) begin
                n_fail++;
                $display("FAIL mul_idle_%0d: rdy=%b x=%h y=%h c=%b", i, req_ready, alu_x, alu_y, alu_c);
            end
        end
    endtask

    task automatic test_shl();
        logic [15:0] va [3] = '{16'h0001, 16'hABCD, 16'h0005};
        logic [15:0] vb [3] = '{16'h000F, 16'h0010, 16'hFFF3};
        logic [15:0] vr [3] = '{16'h8000, 16'hABCD, 16'h0028};
        logic [5:0]  vc [3] = '{6'b000010, 6'b001100, 6'b000010};
        int          vl [3] = '{15, 1, 3};
        int e;
        for (int i = 0; i < 3; i++) begin
            send(2'b10, 6'b000000, va[i], vb[i]);
            n_checks++;
            if (alu_c !== vc[i] || alu_x !== va[i] || alu_y !== va[i]) begin
                n_fail++;
                $display("FAIL shl_drive_%0d: c=%b x=%h y=%h, want %b %h %h", i, alu_c, alu_x, alu_y, vc[i], va[i], va[i]);
            end
            wait_done(e);
            n_checks++;
            if (e !== vl[i] || res_data !== vr[i]) begin
                n_fail++;
                $display("FAIL shl_%0d: edges=%0d data=%h, want %0d %h", i, e, res_data, vl[i], vr[i]);
            end
            take();
            n_checks++;
            if (req_ready !== 1'b1 || alu_x !== 16'h0000 || alu_y !== 16'h0000 || alu_c !== C_ZERO) begin
                n_fail++;
                $display("FAIL shl_idle_%0d: rdy=%b x=%h y=%h c=%b", i, req_ready, alu_x, alu_y, alu_c);
            end
        end
    endtask

    task automatic test_zero();
        int e;
        send(2'b11, C_ADD, 16'hFFFF, 16'hFFFF);
        n_checks++;
        if (alu_c !== C_ZERO || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_drive: c=%b busy=%b, want %b 1", alu_c, busy, C_ZERO);
        end
        wait_done(e);
        n_checks++;
        if (e !== 1 || res_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_result: edges=%0d data=%h, want 1 0000", e, res_data);
        end
        take();
        n_checks++;
        if (req_ready !== 1'b1 || alu_x !== 16'h0000 || alu_y !== 16'h0000 || alu_c !== C_ZERO) begin
            n_fail++;
            $display("FAIL zero_idle: rdy=%b x=%h y=%h c=%b", req_ready, alu_x, alu_y, alu_c);
        end
    endtask

    task automatic test_backpressure();
        int e;
        send(2'b00, C_ADD, 16'h1111, 16'h2222);
        wait_done(e);
        n_checks++;
        if (e !== 1 || res_data !== 16'h3333) begin
            n_fail++;
            $display("FAIL bp_result: edges=%0d data=%h, want 1 3333", e, res_data);
        end
        req_op    = 2'b00;
        req_c     = C_ADD;
        req_a     = 16'h0100;
        req_b     = 16'h0200;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (res_data !== 16'h3333 || res_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: data=%h vld=%b rdy=%b busy=%b, want 3333 1 0 0",
                         i, res_data, res_valid, req_ready, busy);
            end
        end
        req_valid = 1'b0;
        take();
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 16'h3333) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b data=%h, want 1 0 3333", req_ready, res_valid, res_data);
        end
    endtask

    task automatic test_reset_mid_mul();
        int e;
        int seen_valid;
        send(2'b01, 6'b000000, 16'h0007, 16'h0006);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 16'h0000 ||
            alu_x !== 16'h0000 || alu_y !== 16'h0000 || alu_c !== C_ZERO) begin
            n_fail++;
            $display("FAIL rst_mid: rdy=%b vld=%b busy=%b data=%h x=%h y=%h c=%b",
                     req_ready, res_valid, busy, res_data, alu_x, alu_y, alu_c);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) seen_valid++;
        end
        n_checks++;
        if (seen_valid !== 0) begin
            n_fail++;
            $display("FAIL rst_no_result: active cycles after reset=%0d, want 0", seen_valid);
        end
        send(2'b00, C_ADD, 16'h0001, 16'h0002);
        wait_done(e);
        n_checks++;
        if (e !== 1 || res_data !== 16'h0003) begin
            n_fail++;
            $display("FAIL rst_then_single: edges=%0d data=%h, want 1 0003", e, res_data);
        end
        take();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_c     = 6'b000000;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_mul();
        test_shl();
        test_zero();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that owns the 16-bit Nand2Tetris-style ALU (inputs X, Y, 6-bit control C = {zx,nx,zy,ny,f,no}; combinational output) and drives it for one operation at a time. A requester hands over an operation through a valid/ready handshake. The block runs one or more ALU cycles and returns a registered 16-bit result through a second valid/ready handshake. It sits between instruction decode and the ALU, and gives the CPU multiply and variable left-shift without a second adder.

## Interface
Parameters:
- none; data width is fixed at 16 and control width at 6.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high exactly when state is IDLE
- req_op  in  2  operation: 00 SINGLE, 01 MUL, 10 SHL, 11 ZERO
- req_c  in  6  ALU control word; used only by SINGLE
- req_a  in  16  operand A
- req_b  in  16  operand B (multiplier for MUL; count in bits [3:0] for SHL)
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  16  result register
- busy  out  1  high in EXEC state
- alu_x  out  16  drives ALU X
- alu_y  out  16  drives ALU Y
- alu_c  out  6  drives ALU C
- alu_out  in  16  ALU output, combinational from alu_x/alu_y/alu_c

## Operation
- States and transitions:
  - IDLE: goes to EXEC on an edge with req_valid=1. At that edge the block latches op, c, acc=req_a, a_sh=req_a, b_sh=req_b and cnt.
  - EXEC: runs the ALU cycles described below. Goes to DONE on its final edge and writes alu_out into res_data.
  - DONE: holds res_valid=1. Goes to IDLE on an edge with res_ready=1.
- req_ready is 0 in EXEC and DONE. A request is never accepted in the same cycle a result is taken.
- Fixed ALU control words: ADD=6'b000010, PASSX=6'b001100, ZERO=6'b101010.
- ALU drive while not in EXEC: alu_x=0, alu_y=0, alu_c=ZERO.
- SINGLE: one EXEC cycle. alu_x=A, alu_y=B, alu_c=latched req_c.
- ZERO (op 11): one EXEC cycle with alu_c=ZERO. The result is 0x0000.
- MUL: one ALU cycle per multiplier bit.
  - Drive: alu_x=acc, alu_y=a_sh, alu_c = b_sh[0] ? ADD : PASSX.
  - acc is initialised to 0 at accept, not to A.
  - Each edge: acc<=alu_out, a_sh<=a_sh<<1, b_sh<=b_sh>>1, cnt<=cnt+1.
  - The operation ends after 16 iterations. The result is the low 16 bits of A*B; overflow is silently dropped.
- SHL: alu_x=alu_y=acc, alu_c=ADD, acc<=alu_out each cycle.
  - Runs n=req_b[3:0] cycles. req_b[15:4] are ignored.
  - When n=0, runs one cycle with PASSX, so the result is A.
- res_data holds its value from the DONE entry edge until the next DONE entry. It is not cleared on the return to IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, res_valid=0, res_data=0x0000, busy=0, alu_x=0, alu_y=0, alu_c=ZERO. Internal registers are 0.
- Latency from the accepting edge to the DONE entry edge (res_valid high after it):
  - SINGLE/ZERO: 1 edge
  - MUL: 16 edges (see Configuration)
  - SHL: max(n,1) edges
- Minimum back-to-back spacing is latency+2 cycles: the DONE cycle plus one IDLE cycle.
- res_ready low: the block stays in DONE indefinitely. res_data and res_valid are stable. req_valid is ignored.
- res_ready high on the DONE entry cycle is honoured on the next edge, so DONE lasts at least one cycle.
- Reset asserted mid-EXEC or mid-DONE: immediate return to reset values. The result is discarded and no res_valid pulse is produced.
- Input values of req_* outside the accepting edge are don't-care.

## Configuration
- ALU_SEQ_EARLY_EXIT_EN defined: MUL ends on the first edge where the shifted b_sh becomes 0. The minimum is 1 edge, which is B=0 and gives result 0. Latency equals the bit index of B's MSB plus 1.
- ALU_SEQ_EARLY_EXIT_EN undefined: MUL always takes 16 edges.
- SINGLE, ZERO and SHL are unaffected by the macro.

## Test plan
- SINGLE: op=00, c=000000 (AND), A=0x0F0F, B=0x00FF. Expect res_data=0x000F, res_valid 1 edge after accept, busy high for exactly 1 cycle.
- MUL: A=0x0007, B=0x0006. Expect 0x002A after 16 edges (3 edges with EARLY_EXIT). Also A=0x1234, B=0x0100 gives 0x3400, and A=0xFFFF, B=0xFFFF gives 0x0001.
- SHL: A=0x0001, B=0x000F gives 0x8000 after 15 edges. A=0xABCD, B=0x0010 (n=0) gives 0xABCD after 1 edge with alu_c=PASSX observed.
- Backpressure: hold res_ready=0 for 5 cycles after DONE while driving req_valid=1 with a new request. Expect res_data stable, req_ready=0 and no accept. Release res_ready, then req_ready=1 one edge later.
- Reset mid-MUL: assert reset asynchronously 4 cycles after accept. Expect outputs at reset values immediately, no res_valid, and a subsequent SINGLE to complete normally.
- ZERO op with A=B=0xFFFF gives 0x0000. Check ALU drive (x=0, y=0, c=ZERO) in IDLE after every operation.
